seq_gen_tx: RTL and testbench

- Serial sequence generator: the transmit end for the team's serial shift-register pattern detectors.
- On `start`, latches a WIDTH-bit word and shifts it out MSB-first on `dout`, one bit per `clk`.
- Repeats the word a programmable number of times, with an idle gap of all-zero bits between repeats.
- `dout` drives a detector's `din` directly on the same debounced or system clock.

---
 rtl/seq_gen_tx.sv | 129 ++++++++++++
 tb/tb_seq_gen_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_gen_tx.sv
// Serial word transmitter: shifts a latched WIDTH-bit word out MSB-first, repeated with zero gaps.
// Optional even-parity bit per word when SEQ_GEN_TX_PARITY_EN is defined.
module seq_gen_tx #(
  parameter int              WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = 6'b101011,
  parameter int              GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_pat,
  input  logic [WIDTH-1:0] data_i,
  input  logic [3:0]       rep,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       word_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

`ifdef SEQ_GEN_TX_PARITY_EN
  localparam logic [4:0] LAST_BIT = 5'(WIDTH);
`else
  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);
`endif
  localparam logic [3:0] GAP_LAST = (GAP_LEN == 0) ? 4'd0 : 4'(GAP_LEN - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg, word_q;
  logic [3:0]       reps_q;
  logic [4:0]       bit_cnt;
  logic [3:0]       gap_cnt;
  logic             load, reload, word_end, more_words, out_bit;
  logic [WIDTH-1:0] word_in;

  assign word_in    = use_pat ? PATTERN : data_i;
  assign more_words = ({1'b0, word_cnt} + 5'd1) < {1'b0, reps_q};

`ifdef SEQ_GEN_TX_PARITY_EN
  assign out_bit = (bit_cnt == 5'(WIDTH)) ? ^word_q : shreg[WIDTH-1];
`else
  assign out_bit = shreg[WIDTH-1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dout     = 1'b0;
    valid    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    load     = 1'b0;
    reload   = 1'b0;
    word_end = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        dout  = out_bit;
        valid = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          word_end = 1'b1;
          if (!more_words) begin
            state_d = DONE;
          end else if (GAP_LEN == 0) begin
            reload  = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          reload  = 1'b1;
          state_d = SHIFT;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: the word is captured once per burst; every repeat reloads from that copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      word_q   <= '0;
      reps_q   <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      if (load) begin
        word_q   <= word_in;
        shreg    <= word_in;
        reps_q   <= (rep == 4'd0) ? 4'd1 : rep;
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else if (reload) begin
        shreg <= word_q;
      end else if (state_q == SHIFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end

      if (state_q == SHIFT) begin
        bit_cnt <= word_end ? 5'd0 : bit_cnt + 5'd1;
        if (word_end) word_cnt <= word_cnt + 4'd1;
      end

      gap_cnt <= (state_q == GAP) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Scoreboard bench for seq_gen_tx: per-cycle expected outputs queued at start, compared each cycle.
module tb_seq_gen_tx;

  localparam int WIDTH   = 6;
  localparam int GAP_LEN = 2;

  typedef struct packed {
    logic       dout;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] wc;
  } item_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             use_pat = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [3:0]       rep = '0;
  logic             dout, valid, busy, done;
  logic [3:0]       word_cnt;

  item_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  logic [5:0] det_sr;
  logic       found, found_d = 1'b0;
  int         det_rises = 0;

  seq_gen_tx #(.WIDTH(WIDTH), .PATTERN(6'b101011), .GAP_LEN(GAP_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .use_pat(use_pat), .data_i(data_i),
    .rep(rep), .dout(dout), .valid(valid), .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // 6-bit 101011 detector fed straight from dout
  always @(posedge clk or posedge reset) begin
    if (reset) det_sr <= '0;
    else       det_sr <= {det_sr[4:0], dout};
  end
  assign found = (det_sr == 6'b101011);

  always @(negedge clk) begin
    if (found && !found_d) det_rises = det_rises + 1;
    found_d = found;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_burst(input logic [WIDTH-1:0] w, input logic [3:0] r);
    int n;
    n = (r == 0) ? 1 : int'(r);
    for (int k = 0; k < n; k++) begin
      for (int i = WIDTH - 1; i >= 0; i--)
        exp_q.push_back('{dout: w[i], valid: 1'b1, busy: 1'b1, done: 1'b0, wc: 4'(k)});
`ifdef SEQ_GEN_TX_PARITY_EN
      exp_q.push_back('{dout: ^w, valid: 1'b1, busy: 1'b1, done: 1'b0, wc: 4'(k)});
`endif
      if (k < n - 1)
        for (int g = 0; g < GAP_LEN; g++)
          exp_q.push_back('{dout: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0, wc: 4'(k + 1)});
    end
    exp_q.push_back('{dout: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b1, wc: 4'(n)});
    exp_q.push_back('{dout: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, wc: 4'(n)});
  endtask

  task automatic run_burst(input string name, input logic up, input logic [WIDTH-1:0] d,
                           input logic [3:0] r, input int rst_at, input int poke_at,
                           input bit chk_det);
    item_t it;
    int    idx;
    int    rises0;
    @(negedge clk);
    use_pat = up;
    data_i  = d;
    rep     = r;
    start   = 1'b1;
    push_burst(up ? WIDTH'(6'b101011) : d, r);
    rises0 = det_rises;
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      chk($sformatf("%s dout[%0d]", name, idx), 32'(dout), 32'(it.dout));
      chk($sformatf("%s valid[%0d]", name, idx), 32'(valid), 32'(it.valid));
      chk($sformatf("%s busy[%0d]", name, idx), 32'(busy), 32'(it.busy));
      chk($sformatf("%s done[%0d]", name, idx), 32'(done), 32'(it.done));
      chk($sformatf("%s word_cnt[%0d]", name, idx), 32'(word_cnt), 32'(it.wc));
      if (chk_det && idx == WIDTH)
        chk($sformatf("%s found[%0d]", name, idx), 32'(found), 32'd1);
      if (idx == rst_at) begin
        reset = 1'b1;
        #1;
        chk({name, " rst dout"}, 32'(dout), 32'd0);
        chk({name, " rst valid"}, 32'(valid), 32'd0);
        chk({name, " rst busy"}, 32'(busy), 32'd0);
        chk({name, " rst done"}, 32'(done), 32'd0);
        chk({name, " rst word_cnt"}, 32'(word_cnt), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      start = (idx == poke_at) ? 1'b1 : 1'b0;
      if (idx == poke_at) begin
        data_i  = ~d;
        use_pat = ~up;
        rep     = 4'hf;
      end
      idx = idx + 1;
      @(negedge clk);
    end
    start = 1'b0;
    if (chk_det) chk({name, " found rises"}, 32'(det_rises - rises0), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_burst("pattern", 1'b1, 6'b000000, 4'd0, -1, -1, 1'b1);
    run_burst("repeats", 1'b0, 6'b110010, 4'd3, -1, -1, 1'b0);
    run_burst("busy", 1'b0, 6'b011101, 4'd1, -1, 2, 1'b0);
    run_burst("midreset", 1'b0, 6'b110010, 4'd3, WIDTH + GAP_LEN + 3, -1, 1'b0);
    run_burst("fresh", 1'b0, 6'b110010, 4'd3, -1, -1, 1'b0);
    run_burst("par_odd", 1'b0, 6'b100000, 4'd1, -1, -1, 1'b0);
    run_burst("par_even", 1'b0, 6'b101011, 4'd1, -1, -1, 1'b0);
    run_burst("maxrep", 1'b0, 6'b000001, 4'd15, -1, -1, 1'b0);

    repeat (2) @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle word_cnt hold", 32'(word_cnt), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
